// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port IMEM between the fetch stage
// and a loader, with round-robin sharing, a loader lock mode and misalignment rejection.
module imem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int BURST_MAX = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     F_Req,
    input  logic [ADDR_W-1:0]        F_Addr,
    output logic                     F_Gnt,
    output logic                     F_Valid,
    output logic [31:0]              F_Instr,
    input  logic                     L_Req,
    input  logic                     L_We,
    input  logic                     L_Lock,
    input  logic [ADDR_W-1:0]        L_Addr,
    input  logic [31:0]              L_WData,
    output logic                     L_Gnt,
    output logic                     L_Valid,
    output logic [31:0]              L_RData,
    output logic                     Err,
    output logic                     M_En,
    output logic                     M_We,
    output logic [$clog2(DEPTH)-1:0] M_Addr,
    output logic [31:0]              M_WData,
    input  logic [31:0]              M_RData
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, SHARED, LOCKED} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     burst, burst_n;
    logic              last_l;
    logic              own_f, own_l;
    logic [31:0]       f_instr_q, l_rdata_q;
    logic              f_gnt, l_gnt, gnt, ok, lock_act;
    logic [ADDR_W-1:0] sel_addr;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_W'(DEPTH));
    endfunction

    // Lock only dominates while L_Lock is still high; the release cycle arbitrates normally.
    assign lock_act = (state == LOCKED) && L_Lock;

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (Reset) begin
            if (lock_act) begin
                if (F_Req && burst == CW'(BURST_MAX)) f_gnt = 1'b1;
                else if (L_Req)                       l_gnt = 1'b1;
            end else if (F_Req && L_Req) begin
                f_gnt = last_l;
                l_gnt = ~last_l;
            end else begin
                f_gnt = F_Req;
                l_gnt = L_Req;
            end
        end
    end

    assign sel_addr = f_gnt ? F_Addr : L_Addr;
    assign ok       = addr_ok(sel_addr);
    assign gnt      = f_gnt | l_gnt;
    assign F_Gnt    = f_gnt;
    assign L_Gnt    = l_gnt;
    assign M_En     = gnt & ok;
    assign M_We     = l_gnt & ok & L_We;
    assign Err      = gnt & ~ok;
    assign M_Addr   = M_En ? sel_addr[AW+1:2] : '0;
    assign M_WData  = L_WData;

    always_comb begin
        state_n = state;
        burst_n = '0;
        unique case (state)
            IDLE, SHARED: begin
                if (l_gnt && L_Lock && L_Req) begin
                    state_n = LOCKED;
                    burst_n = CW'(1);
                end else if (F_Req || L_Req) begin
                    state_n = SHARED;
                end else begin
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                if (!L_Lock)     state_n = SHARED;
                else if (f_gnt)  burst_n = '0;
                else if (l_gnt)  burst_n = (burst == CW'(BURST_MAX)) ? burst : burst + CW'(1);
                else             burst_n = burst;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            burst     <= '0;
            last_l    <= 1'b0;
            own_f     <= 1'b0;
            own_l     <= 1'b0;
            f_instr_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state <= state_n;
            burst <= burst_n;
            if (gnt) last_l <= l_gnt;
            own_f <= f_gnt & ok;
            own_l <= l_gnt & ok & ~L_We;
            if (own_f) f_instr_q <= M_RData;
            if (own_l) l_rdata_q <= M_RData;
        end
    end

    // Memory returns data one cycle after M_En; the owner tag routes it, the other port holds.
    assign F_Valid = own_f;
    assign L_Valid = own_l;
    assign F_Instr = own_f ? M_RData : f_instr_q;
    assign L_RData = own_l ? M_RData : l_rdata_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level reference model and a write-first memory.
module tb_imem_arbiter;
    localparam int ADDR_W = 32, DEPTH = 1024, BURST_MAX = 8;

    logic        Clk = 1'b0, Reset = 1'b0;
    logic        F_Req = 0, L_Req = 0, L_We = 0, L_Lock = 0;
    logic [31:0] F_Addr = 0, L_Addr = 0, L_WData = 0;
    logic        F_Gnt, F_Valid, L_Gnt, L_Valid, Err, M_En, M_We;
    logic [31:0] F_Instr, L_RData, M_WData, M_RData;
    logic [9:0]  M_Addr;

    imem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
        .Clk(Clk), .Reset(Reset),
        .F_Req(F_Req), .F_Addr(F_Addr), .F_Gnt(F_Gnt), .F_Valid(F_Valid), .F_Instr(F_Instr),
        .L_Req(L_Req), .L_We(L_We), .L_Lock(L_Lock), .L_Addr(L_Addr), .L_WData(L_WData),
        .L_Gnt(L_Gnt), .L_Valid(L_Valid), .L_RData(L_RData), .Err(Err),
        .M_En(M_En), .M_We(M_We), .M_Addr(M_Addr), .M_WData(M_WData), .M_RData(M_RData)
    );

    always #5 Clk = ~Clk;

    int n_err = 0, n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'd3;
    endfunction

    // Write-first single-port memory.
    logic [31:0] mem    [DEPTH];
    logic [31:0] shadow [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) begin
        mem[i]    = init_word(i);
        shadow[i] = init_word(i);
    end
    always @(posedge Clk) if (M_En) begin
        if (M_We) begin
            mem[M_Addr] <= M_WData;
            M_RData     <= M_WData;
        end else begin
            M_RData <= mem[M_Addr];
        end
    end

    // Reference model: who may use the memory this cycle, and what each port must show.
    bit          m_locked = 0, m_last_l = 0;
    int          m_burst = 0;
    bit          pend_f = 0, pend_l = 0;
    logic [31:0] exp_fd = 0, exp_ld = 0, hold_f = 0, hold_l = 0;
    bit          e_fg, e_lg, e_ok;
    logic [31:0] e_addr;

    initial forever begin
        @(negedge Clk);
        #2;
        if (!Reset) begin
            m_locked = 0; m_last_l = 0; m_burst = 0;
            pend_f = 0; pend_l = 0; hold_f = 0; hold_l = 0;
        end
        e_fg = 0; e_lg = 0;
        if (Reset) begin
            if (m_locked && L_Lock) begin
                if (F_Req && m_burst >= BURST_MAX) e_fg = 1;
                else if (L_Req)                    e_lg = 1;
            end else if (F_Req && L_Req) begin
                e_fg = m_last_l;
                e_lg = !m_last_l;
            end else begin
                e_fg = F_Req;
                e_lg = L_Req;
            end
        end
        e_addr = e_fg ? F_Addr : L_Addr;
        e_ok   = (e_addr % 4 == 0) && (e_addr / 4 < DEPTH);
        chk("f_gnt", F_Gnt, e_fg);
        chk("l_gnt", L_Gnt, e_lg);
        chk("err",   Err,  (e_fg || e_lg) && !e_ok);
        chk("m_en",  M_En, (e_fg || e_lg) && e_ok);
        chk("m_we",  M_We, e_lg && e_ok && L_We);
        if ((e_fg || e_lg) && e_ok) chk("m_addr", M_Addr, e_addr / 4);
        if (e_lg && e_ok && L_We)   chk("m_wdata", M_WData, L_WData);
        chk("f_valid", F_Valid, pend_f);
        chk("f_instr", F_Instr, pend_f ? exp_fd : hold_f);
        chk("l_valid", L_Valid, pend_l);
        chk("l_rdata", L_RData, pend_l ? exp_ld : hold_l);
        @(posedge Clk);
        if (Reset) begin
            if (pend_f) hold_f = exp_fd;
            if (pend_l) hold_l = exp_ld;
            pend_f = e_fg && e_ok;
            pend_l = e_lg && e_ok && !L_We;
            if (pend_f) exp_fd = shadow[e_addr / 4];
            if (pend_l) exp_ld = shadow[e_addr / 4];
            if (e_lg && e_ok && L_We) shadow[e_addr / 4] = L_WData;
            if (e_fg || e_lg) m_last_l = e_lg;
            if (m_locked) begin
                if (!L_Lock) begin m_locked = 0; m_burst = 0; end
                else if (e_fg) m_burst = 0;
                else if (e_lg && m_burst < BURST_MAX) m_burst++;
            end else if (e_lg && L_Lock) begin
                m_locked = 1;
                m_burst  = 1;
            end
        end
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                         input logic lk, input logic [31:0] la, input logic [31:0] ld);
        @(negedge Clk);
        F_Req = fr; F_Addr = fa; L_Req = lr; L_We = lw; L_Lock = lk; L_Addr = la; L_WData = ld;
        #3;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        if (r == 1) return 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        return 32'($urandom_range(0, 63)) * 4;
    endfunction

    int idx, nf, first_f;
    bit lv_seen, lk_r;

    initial begin
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_f_gnt", F_Gnt, 0);
        chk("rst_f_valid", F_Valid, 0);
        chk("rst_f_instr", F_Instr, 0);
        Reset = 1;

        // Repeated fetch of word 2: grant every cycle, data streams one cycle later.
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 32'h8, 0, 0, 0, 0, 0);
            if (i < 3) begin
                chk("seq_f_gnt", F_Gnt, 1);
                chk("seq_m_addr", M_Addr, 2);
            end
            if (i > 0) begin
                chk("seq_f_valid", F_Valid, 1);
                chk("seq_f_instr", F_Instr, init_word(2));
            end
        end

        // Tie stream: loader, fetch, loader, fetch.
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, 32'h8, i < 4, 0, 0, 32'h10, 0);
            if (i < 4) begin
                chk("rr_l_gnt", L_Gnt, (i % 2) == 0);
                chk("rr_f_gnt", F_Gnt, (i % 2) == 1);
            end
            if (i > 0) begin
                chk("rr_l_valid", L_Valid, ((i - 1) % 2) == 0);
                chk("rr_f_valid", F_Valid, ((i - 1) % 2) == 1);
                if ((i - 1) % 2 == 0) chk("rr_l_rdata", L_RData, init_word(4));
            end
        end

        // Misaligned and out-of-range fetches.
        drive(1, 32'h6, 0, 0, 0, 0, 0);
        chk("mis_gnt", F_Gnt, 1); chk("mis_err", Err, 1); chk("mis_m_en", M_En, 0);
        drive(1, 32'h1000, 0, 0, 0, 0, 0);
        chk("oor_gnt", F_Gnt, 1); chk("oor_err", Err, 1); chk("oor_m_en", M_En, 0);
        chk("mis_no_valid", F_Valid, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("oor_no_valid", F_Valid, 0);

        // Write then immediate fetch of the same word.
        drive(0, 0, 1, 1, 0, 32'h20, 32'hDEADBEEF);
        chk("wr_l_gnt", L_Gnt, 1); chk("wr_m_we", M_We, 1);
        drive(1, 32'h20, 0, 0, 0, 0, 0);
        chk("raw_f_gnt", F_Gnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("raw_f_instr", F_Instr, 32'hDEADBEEF);
        chk("wr_no_l_valid", L_Valid, 0);

        // Locked write burst with fetch pending.
        idx = 0; nf = 0; first_f = -1; lv_seen = 0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            drive(1, 32'h40, 1, 1, 1, 32'(idx) * 4, $urandom);
            if (L_Valid) lv_seen = 1;
            if (F_Gnt) begin
                nf++;
                if (first_f < 0) first_f = idx;
            end
            if (L_Gnt) idx++;
        end
        chk("burst_l_cnt", idx, 16);
        chk("burst_f_cnt", nf, 1);
        chk("burst_first_f", first_f, 8);
        chk("burst_no_l_valid", lv_seen, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset the cycle after a fetch grant: no valid survives.
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        chk("rst_pre_f_gnt", F_Gnt, 1);
        @(negedge Clk); Reset = 0; F_Req = 0; #3;
        chk("rst_drop_valid", F_Valid, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        Reset = 1;
        // Loader granted last, then reset: next tie still goes to loader.
        drive(0, 0, 1, 0, 0, 32'h4, 0);
        chk("rst2_l_gnt", L_Gnt, 1);
        @(negedge Clk); Reset = 0; L_Req = 0; #3;
        chk("rst2_drop_valid", L_Valid, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        Reset = 1;
        drive(1, 32'h8, 1, 0, 0, 32'hC, 0);
        chk("rst_tie_l", L_Gnt, 1);
        chk("rst_tie_f", F_Gnt, 0);

        // Randomized traffic, checked by the model.
        lk_r = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) lk_r = !lk_r;
            @(negedge Clk);
            Reset   = ($urandom_range(0, 299) != 0);
            F_Req   = ($urandom_range(0, 2) != 0);
            F_Addr  = rand_addr();
            L_Req   = ($urandom_range(0, 2) != 0);
            L_We    = $urandom_range(0, 1);
            L_Lock  = lk_r;
            L_Addr  = rand_addr();
            L_WData = $urandom;
        end
        @(negedge Clk);
        Reset = 1; F_Req = 0; L_Req = 0; L_Lock = 0;
        repeat (3) @(negedge Clk);
        #4;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
